// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer and the ALU: ALU opcodes, command
// opcodes and sequencer FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_NOP   = 4'd0,
    ALU_REGA  = 4'd1,
    ALU_ADD   = 4'd2,
    ALU_SUB   = 4'd3,
    ALU_AND   = 4'd4,
    ALU_OR    = 4'd5,
    ALU_XOR   = 4'd6,
    ALU_OUT   = 4'd7,
    ALU_RESET = 4'd8
  } alu_op_e;

  typedef enum logic [2:0] {
    CMD_CLR  = 3'd0,
    CMD_ADD  = 3'd1,
    CMD_SUB  = 3'd2,
    CMD_AND  = 3'd3,
    CMD_OR   = 3'd4,
    CMD_XOR  = 3'd5,
    CMD_READ = 3'd6,
    CMD_RSVD = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_LOAD, ST_EXEC, ST_CLEAR, ST_OUT, ST_WAIT, ST_RSP
  } state_e;

  // Data commands ADD..XOR map onto ALU opcodes by a fixed offset of one.
  function automatic alu_op_e map_op(input cmd_op_e op);
    return alu_op_e'({1'b0, op} + 4'd1);
  endfunction

endpackage

// File: rtl/alu.sv
// Accumulator ALU: REGA latches the operand, arithmetic ops update the
// accumulator, OUT presents it after RESULT_LAT cycles.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RESULT_LAT = 1
) (
  input  logic                  clk,
  input  logic                  a_reset_n,
  input  logic [3:0]            i_opcode,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] r_acc, r_rega;
  logic [DATA_WIDTH-1:0] r_pipe [RESULT_LAT];

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      r_acc  <= '0;
      r_rega <= '0;
      for (int i = 0; i < RESULT_LAT; i++) r_pipe[i] <= '0;
    end else begin
      case (i_opcode)
        ALU_REGA:  r_rega <= i_data;
        ALU_ADD:   r_acc  <= r_acc + r_rega;
        ALU_SUB:   r_acc  <= r_acc - r_rega;
        ALU_AND:   r_acc  <= r_acc & r_rega;
        ALU_OR:    r_acc  <= r_acc | r_rega;
        ALU_XOR:   r_acc  <= r_acc ^ r_rega;
        ALU_RESET: begin
          r_acc  <= '0;
          r_rega <= '0;
        end
        default: ;
      endcase
      if (i_opcode == ALU_OUT) r_pipe[0] <= r_acc;
      for (int i = 1; i < RESULT_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[RESULT_LAT-1];

endmodule

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with power-of-two depth; pointers wrap naturally and an
// occupancy counter distinguishes full from empty.
module cmd_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     a_reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign w_push = i_push && (r_count != CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  // NOTE: storage is deliberately not reset; occupancy is tracked by r_count,
  // so stale entries are never observed and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/alu_sequencer.sv
// Queues accumulator commands and sequences them onto a multi-cycle ALU.
// Outputs are registered from the next-state decode so they align with the state.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RESULT_LAT = 1
) (
  input  logic                  clk,
  input  logic                  a_reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [3:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_data_in,
  input  logic [DATA_WIDTH-1:0] alu_data_out,
  output logic                  busy
);

  localparam int FW = DATA_WIDTH + 3;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

  state_e                r_state, w_state_nxt;
  cmd_op_e               r_op, w_head_op;
  alu_op_e               r_alu_opcode, w_opcode_nxt;
  logic [FW-1:0]         w_fifo_rdata;
  logic [DATA_WIDTH-1:0] w_head_data, w_data_in_nxt;
  logic [DATA_WIDTH-1:0] r_alu_data_in, r_rsp_data;
  logic [CW-1:0]         w_count, w_count_nxt;
  logic [LW-1:0]         r_wait_cnt;
  logic                  w_empty, w_push, w_pop;
  logic                  r_cmd_ready, r_rsp_valid, r_busy;

  assign w_push = cmd_valid && r_cmd_ready;

  cmd_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .a_reset_n (a_reset_n),
    .i_push    (w_push),
    .i_data    ({cmd_op, cmd_data}),
    .i_pop     (w_pop),
    .o_data    (w_fifo_rdata),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign w_head_op   = cmd_op_e'(w_fifo_rdata[FW-1 -: 3]);
  assign w_head_data = w_fifo_rdata[DATA_WIDTH-1:0];
  assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_opcode_nxt  = ALU_NOP;
    w_data_in_nxt = r_alu_data_in;

    case (r_state)
      // INIT holds until its RESET opcode has been on the bus for one cycle.
      ST_INIT:  if (r_alu_opcode == ALU_RESET) w_state_nxt = ST_IDLE;
      ST_IDLE:  if (!w_empty) begin
        w_pop = 1'b1;
        case (w_head_op)
          CMD_CLR:  w_state_nxt = ST_CLEAR;
          CMD_READ: w_state_nxt = ST_OUT;
          CMD_RSVD: w_state_nxt = ST_IDLE;
          default:  w_state_nxt = ST_LOAD;
        endcase
      end
      ST_LOAD:  w_state_nxt = ST_EXEC;
      ST_EXEC:  w_state_nxt = ST_IDLE;
      ST_CLEAR: w_state_nxt = ST_IDLE;
      ST_OUT:   w_state_nxt = ST_WAIT;
      ST_WAIT:  if (r_wait_cnt == LW'(RESULT_LAT - 1)) w_state_nxt = ST_RSP;
      ST_RSP:   if (rsp_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_INIT;
    endcase

    case (w_state_nxt)
      ST_INIT, ST_CLEAR: w_opcode_nxt = ALU_RESET;
      ST_LOAD: begin
        w_opcode_nxt  = ALU_REGA;
        w_data_in_nxt = w_head_data;
      end
      ST_EXEC: w_opcode_nxt = map_op(r_op);
      ST_OUT:  w_opcode_nxt = ALU_OUT;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      r_state       <= ST_INIT;
      r_op          <= CMD_CLR;
      r_wait_cnt    <= '0;
      r_alu_opcode  <= ALU_NOP;
      r_alu_data_in <= '0;
      r_rsp_data    <= '0;
      r_rsp_valid   <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_busy        <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_alu_opcode  <= w_opcode_nxt;
      r_alu_data_in <= w_data_in_nxt;
      r_rsp_valid   <= (w_state_nxt == ST_RSP);
      r_cmd_ready   <= (w_state_nxt != ST_INIT) && (w_count_nxt != CW'(FIFO_DEPTH));
      r_busy        <= (w_state_nxt != ST_IDLE) || (w_count_nxt != '0);
      r_wait_cnt    <= (r_state == ST_WAIT) ? r_wait_cnt + LW'(1) : '0;
      if (w_pop) r_op <= w_head_op;
      if (r_state == ST_WAIT && w_state_nxt == ST_RSP) r_rsp_data <= alu_data_out;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign alu_opcode  = r_alu_opcode;
  assign alu_data_in = r_alu_data_in;
  assign busy        = r_busy;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer driving the alu model: vector table,
// response scoreboard and hand-written multi-cycle corner cases.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int DW = 8;

  logic          clk, a_reset_n;
  logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_data, rsp_data, alu_data_in, alu_data_out;
  logic [3:0]    alu_opcode;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs [7];
  logic [3:0] exp_tr [6];
  logic [7:0] sb [$];
  logic [3:0] trace [$];
  bit         trace_en;
  int         n_cmp, n_bad, n_acc, n_rsp, rsp_mark;
  bit         seen;

  alu_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .RESULT_LAT(1)) dut (
    .clk          (clk),
    .a_reset_n    (a_reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .alu_opcode   (alu_opcode),
    .alu_data_in  (alu_data_in),
    .alu_data_out (alu_data_out),
    .busy         (busy)
  );

  alu #(.DATA_WIDTH(DW), .RESULT_LAT(1)) u_alu (
    .clk       (clk),
    .a_reset_n (a_reset_n),
    .i_opcode  (alu_opcode),
    .i_data    (alu_data_in),
    .o_data    (alu_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] data, input logic [7:0] exp = 8'h00);
    bit done;
    done      = 1'b0;
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!done) expired("send_accept");
    else begin
      n_acc++;
      if (op == CMD_READ) sb.push_back(exp);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = (sb.size() == 0) && !busy && !rsp_valid;
    end
    if (!ok) expired("drain");
    sync();
  endtask

  task automatic wait_rsp_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    if (!ok) expired("rsp_valid_wait");
    sync();
  endtask

  // Response scoreboard and ALU opcode trace, sampled away from the active edge.
  always @(negedge clk) begin
    if (a_reset_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got 0x%0h, expected no response", rsp_data);
      end else begin
        check("rsp_data", {24'h0, rsp_data}, {24'h0, sb.pop_front()});
        n_rsp++;
      end
    end
    if (trace_en && alu_opcode != 4'd0) trace.push_back(alu_opcode);
  end

  initial begin
    vecs[0] = '{3'd1, 8'h12, 8'h34, 8'h46, "add"};
    vecs[1] = '{3'd2, 8'h10, 8'h20, 8'hF0, "sub_wrap"};
    vecs[2] = '{3'd3, 8'hF0, 8'h3C, 8'h30, "and"};
    vecs[3] = '{3'd4, 8'hA0, 8'h05, 8'hA5, "or"};
    vecs[4] = '{3'd5, 8'hFF, 8'h0F, 8'hF0, "xor"};
    vecs[5] = '{3'd7, 8'h42, 8'h55, 8'h42, "reserved_dropped"};
    vecs[6] = '{3'd0, 8'h77, 8'h99, 8'h00, "clr"};
    exp_tr  = '{4'd8, 4'd1, 4'd2, 4'd1, 4'd3, 4'd7};

    n_cmp = 0; n_bad = 0; n_acc = 0; n_rsp = 0;
    trace_en  = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b1;
    a_reset_n = 1'b1;
    #2 a_reset_n = 1'b0;

    // Reset values, then INIT RESET pulse and cmd_ready rising after it.
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_alu_opcode", alu_opcode, 0);
    check("rst_alu_data_in", alu_data_in, 0);
    check("rst_busy", busy, 1);
    sync();
    a_reset_n = 1'b1;
    @(negedge clk);
    check("init0_opcode", alu_opcode, 0);
    check("init0_ready", cmd_ready, 0);
    @(negedge clk);
    check("init1_opcode", alu_opcode, 8);
    check("init1_ready", cmd_ready, 0);
    @(negedge clk);
    check("idle_opcode", alu_opcode, 0);
    check("idle_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    sync();

    // Vector table: CLR, ADD a, <op> b, READ.
    for (int i = 0; i < 7; i++) begin
      send(CMD_CLR, 8'h00);
      send(CMD_ADD, vecs[i].a);
      send(vecs[i].op, vecs[i].b);
      send(CMD_READ, 8'h00, vecs[i].exp);
      drain();
    end

    // Opcode trace for CLR, ADD 0x30, SUB 0x10, READ.
    trace.delete();
    trace_en = 1'b1;
    send(CMD_CLR, 8'h00);
    send(CMD_ADD, 8'h30);
    send(CMD_SUB, 8'h10);
    send(CMD_READ, 8'h00, 8'h20);
    drain();
    trace_en = 1'b0;
    check("trace_len", trace.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < trace.size()) check("trace_op", trace[i], exp_tr[i]);

    // Modulo wrap-around.
    send(CMD_CLR, 8'h00);
    send(CMD_ADD, 8'hFF);
    send(CMD_ADD, 8'h02);
    send(CMD_READ, 8'h00, 8'h01);
    drain();

    // FIFO fill while the FSM is parked in RSP; fifth command waits for a pop.
    rsp_ready = 1'b0;
    send(CMD_READ, 8'h00, 8'h01);
    wait_rsp_valid();
    n_acc = 0;
    fork
      begin
        send(CMD_CLR, 8'h00);
        send(CMD_ADD, 8'h05);
        send(CMD_READ, 8'h00, 8'h05);
        send(CMD_ADD, 8'h03);
        send(CMD_READ, 8'h00, 8'h08);
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
          @(negedge clk);
          seen = (n_acc == 4);
        end
        if (!seen) expired("fill_four");
        else begin
          repeat (3) @(negedge clk);
          check("full_ready_low", cmd_ready, 0);
          check("full_accepted", n_acc, 4);
        end
        sync();
        rsp_ready = 1'b1;
      end
    join
    check("fifth_accepted", n_acc, 5);
    drain();

    // Response back-pressure for 10 cycles, then resume one cycle after handshake.
    rsp_ready = 1'b0;
    send(CMD_CLR, 8'h00);
    send(CMD_ADD, 8'h5A);
    send(CMD_READ, 8'h00, 8'h5A);
    send(CMD_ADD, 8'h01);
    send(CMD_READ, 8'h00, 8'h5B);
    wait_rsp_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_rsp_data", rsp_data, 8'h5A);
      check("stall_opcode", alu_opcode, 0);
    end
    sync();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("resume_idle_opcode", alu_opcode, 0);
    check("resume_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check("resume_load_opcode", alu_opcode, 1);
    check("resume_load_data", alu_data_in, 8'h01);
    drain();

    // Reset during EXEC with three commands still queued.
    rsp_ready = 1'b0;
    send(CMD_READ, 8'h00, 8'h5B);
    wait_rsp_valid();
    send(CMD_ADD, 8'h11);
    send(CMD_ADD, 8'h22);
    send(CMD_ADD, 8'h33);
    send(CMD_READ, 8'h00, 8'hEE);
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (alu_opcode == 4'd2);
    end
    if (!seen) expired("exec_wait");
    a_reset_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    check("midrst_busy", busy, 1);
    check("midrst_opcode", alu_opcode, 0);
    sb.delete();
    rsp_mark = n_rsp;
    repeat (2) @(posedge clk);
    #1;
    trace.delete();
    trace_en  = 1'b1;
    a_reset_n = 1'b1;
    repeat (20) @(negedge clk);
    trace_en = 1'b0;
    check("postrst_trace_len", trace.size(), 1);
    if (trace.size() > 0) check("postrst_trace_op", trace[0], 8);
    check("postrst_busy", busy, 0);
    check("postrst_rsp_valid", rsp_valid, 0);
    check("postrst_cmd_ready", cmd_ready, 1);
    check("postrst_no_rsp", n_rsp, rsp_mark);
    sync();
    send(CMD_READ, 8'h00, 8'h00);
    drain();

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
